// File: rtl/titan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : titan_pkg
// Brief   : Shared titan definitions: IF FSM encoding and fetch defaults.
// Revision: 1.0
// ============================================================================
package titan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } if_state_e;

    localparam logic [31:0] C_NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] C_RESET_ADDR = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/titan_ifid_register.sv
`default_nettype none
// ============================================================================
// Module  : titan_ifid_register
// Brief   : IF/ID pipeline register with flush (highest priority) and stall.
// Revision: 1.0
// ============================================================================
module titan_ifid_register
    import titan_pkg::*;
#(
    parameter logic [31:0] NOP_INST = C_NOP_INST
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        misaligned_i,
    input  logic        fault_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        misaligned_o,
    output logic        fault_o
);

    logic [31:0] pc_d, pc_q, inst_d, inst_q;
    logic        mis_d, mis_q, fault_d, fault_q;

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        mis_d   = mis_q;
        fault_d = fault_q;
        if (flush_i) begin
            pc_d    = pc_i;
            inst_d  = NOP_INST;
            mis_d   = 1'b0;
            fault_d = 1'b0;
        end else if (!stall_i && load_i) begin
            pc_d    = pc_i;
            inst_d  = inst_i;
            mis_d   = misaligned_i;
            fault_d = fault_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= 32'd0;
            inst_q  <= NOP_INST;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
        end
    end

    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign misaligned_o = mis_q;
    assign fault_o      = fault_q;

endmodule
`default_nettype wire

// File: rtl/titan_if_stage.sv
`default_nettype none
// ============================================================================
// Module  : titan_if_stage
// Brief   : Instruction fetch stage: PC, redirect, bus FSM and IF/ID register.
// Revision: 1.0
// ============================================================================
module titan_if_stage
    import titan_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = C_RESET_ADDR,
    parameter logic [31:0] NOP_INST   = C_NOP_INST
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_stall_i,
    input  logic        if_flush_i,
    input  logic        take_branch_i,
    input  logic        take_jump_i,
    input  logic [31:0] pc_branch_address_i,
    input  logic [31:0] pc_jump_address_i,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_pc_i,
    output logic [31:0] iport_addr_o,
    output logic        iport_cyc_o,
    output logic        iport_stb_o,
    input  logic [31:0] iport_dat_i,
    input  logic        iport_ack_i,
    input  logic        iport_err_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instruction_o,
    output logic        id_inst_addr_misaligned_o,
    output logic        id_inst_access_fault_o,
    output logic        if_busy_o
);

    if_state_e   state_d, state_q;
    logic [31:0] pc_d, pc_q, target_d, target_q, buf_inst_d, buf_inst_q;
    logic        buf_fault_d, buf_fault_q;

    logic        redirect, bus_done, bus_req;
    logic [31:0] redirect_target, pc_seq, resp_inst;
    logic        ifid_load, ifid_mis, ifid_fault;
    logic [31:0] ifid_inst;

    assign redirect        = trap_valid_i | take_jump_i | take_branch_i;
    assign redirect_target = trap_valid_i ? trap_pc_i :
                             take_jump_i  ? pc_jump_address_i : pc_branch_address_i;
    assign pc_seq          = pc_q + 32'd4;
    assign bus_done        = iport_ack_i | iport_err_i;
    assign resp_inst       = iport_err_i ? NOP_INST : iport_dat_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        buf_inst_d  = buf_inst_q;
        buf_fault_d = buf_fault_q;
        ifid_load   = 1'b0;
        ifid_inst   = resp_inst;
        ifid_mis    = 1'b0;
        ifid_fault  = iport_err_i;
        bus_req     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end else if (pc_q[1:0] != 2'b00) begin
                    // Misaligned PC: bubble with the flag, no bus cycle; wait for the trap redirect.
                    if (!if_stall_i) begin
                        ifid_load  = 1'b1;
                        ifid_inst  = NOP_INST;
                        ifid_mis   = 1'b1;
                        ifid_fault = 1'b0;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                bus_req = 1'b1;
                if (bus_done) begin
                    state_d = ST_IDLE;
                    if (redirect) begin
                        pc_d = redirect_target;
                    end else if (if_stall_i) begin
                        buf_inst_d  = resp_inst;
                        buf_fault_d = iport_err_i;
                        state_d     = ST_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_seq;
                    end
                end else if (redirect) begin
                    target_d = redirect_target;
                    state_d  = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (redirect || !if_stall_i) begin
                    ifid_load   = !redirect;
                    ifid_inst   = buf_inst_q;
                    ifid_fault  = buf_fault_q;
                    pc_d        = redirect ? redirect_target : pc_seq;
                    buf_inst_d  = NOP_INST;
                    buf_fault_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                // The bus cycle cannot be abandoned; wait it out and drop the response.
                bus_req = 1'b1;
                if (bus_done) begin
                    pc_d    = redirect ? redirect_target : target_q;
                    state_d = ST_IDLE;
                end else if (redirect) begin
                    target_d = redirect_target;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_ADDR;
            target_q    <= 32'd0;
            buf_inst_q  <= NOP_INST;
            buf_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            buf_inst_q  <= buf_inst_d;
            buf_fault_q <= buf_fault_d;
        end
    end

    assign iport_addr_o = pc_q;
    assign iport_cyc_o  = bus_req;
    assign iport_stb_o  = bus_req;
    assign if_busy_o    = (state_q == ST_FETCH) || (state_q == ST_DISCARD);

    titan_ifid_register #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (if_stall_i),
        .flush_i      (if_flush_i),
        .load_i       (ifid_load),
        .pc_i         (pc_q),
        .inst_i       (ifid_inst),
        .misaligned_i (ifid_mis),
        .fault_i      (ifid_fault),
        .pc_o         (id_pc_o),
        .inst_o       (id_instruction_o),
        .misaligned_o (id_inst_addr_misaligned_o),
        .fault_o      (id_inst_access_fault_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_titan_if_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_titan_if_stage
// Brief   : Directed self-checking bench for titan_if_stage.
// Revision: 1.0
// ============================================================================
module tb_titan_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_stall_i = 0, if_flush_i = 0, take_branch_i = 0, take_jump_i = 0;
    logic [31:0] pc_branch_address_i = 0, pc_jump_address_i = 0, trap_pc_i = 0;
    logic        trap_valid_i = 0;
    logic [31:0] iport_addr_o, iport_dat_i = 0;
    logic        iport_cyc_o, iport_stb_o, iport_ack_i = 0, iport_err_i = 0;
    logic [31:0] id_pc_o, id_instruction_o;
    logic        id_inst_addr_misaligned_o, id_inst_access_fault_o, if_busy_o;

    int vec = 0, errs = 0;

    always #5 clk = ~clk;

    titan_if_stage dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .if_stall_i                (if_stall_i),
        .if_flush_i                (if_flush_i),
        .take_branch_i             (take_branch_i),
        .take_jump_i               (take_jump_i),
        .pc_branch_address_i       (pc_branch_address_i),
        .pc_jump_address_i         (pc_jump_address_i),
        .trap_valid_i              (trap_valid_i),
        .trap_pc_i                 (trap_pc_i),
        .iport_addr_o              (iport_addr_o),
        .iport_cyc_o               (iport_cyc_o),
        .iport_stb_o               (iport_stb_o),
        .iport_dat_i               (iport_dat_i),
        .iport_ack_i               (iport_ack_i),
        .iport_err_i               (iport_err_i),
        .id_pc_o                   (id_pc_o),
        .id_instruction_o          (id_instruction_o),
        .id_inst_addr_misaligned_o (id_inst_addr_misaligned_o),
        .id_inst_access_fault_o    (id_inst_access_fault_o),
        .if_busy_o                 (if_busy_o)
    );

    // Waits (bounded) for a bus request; an expired bound counts as a miscompare.
    task automatic wait_stb();
        int n = 0;
        while (iport_stb_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (iport_stb_o !== 1'b1) begin errs++; $display("FAIL wait_stb: stb=%b required 1 within 20 cycles", iport_stb_o); end
    endtask

    task automatic bus_resp(input logic [31:0] d, input logic e);
        iport_dat_i = d;
        iport_ack_i = ~e;
        iport_err_i = e;
        @(negedge clk);
        iport_ack_i = 1'b0;
        iport_err_i = 1'b0;
        iport_dat_i = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vec++; if (iport_cyc_o !== 1'b0) begin errs++; $display("FAIL reset_cyc: got %b required 0", iport_cyc_o); end
        vec++; if (id_pc_o !== 32'h0) begin errs++; $display("FAIL reset_id_pc: got %h required 00000000", id_pc_o); end
        vec++; if (id_instruction_o !== NOP) begin errs++; $display("FAIL reset_id_inst: got %h required %h", id_instruction_o, NOP); end
        vec++; if ({id_inst_addr_misaligned_o, id_inst_access_fault_o, if_busy_o} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b required 000", {id_inst_addr_misaligned_o, id_inst_access_fault_o, if_busy_o}); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] a, d;
        for (int i = 0; i < 3; i++) begin
            a = 32'h8000_0000 + 32'(4 * i);
            d = 32'h1111_0000 + 32'(i);
            wait_stb();
            vec++; if (iport_addr_o !== a) begin errs++; $display("FAIL seq_addr%0d: got %h required %h", i, iport_addr_o, a); end
            bus_resp(d, 1'b0);
            vec++; if (id_pc_o !== a || id_instruction_o !== d) begin errs++; $display("FAIL seq_id%0d: got %h/%h required %h/%h", i, id_pc_o, id_instruction_o, a, d); end
        end
    endtask

    task automatic test_jump_discard();
        do_reset();
        wait_stb(); bus_resp(32'hA000_0000, 1'b0);
        wait_stb(); bus_resp(32'hA000_0004, 1'b0);
        wait_stb();
        vec++; if (iport_addr_o !== 32'h8000_0008) begin errs++; $display("FAIL jmp_addr_pre: got %h required 80000008", iport_addr_o); end
        take_jump_i = 1'b1; pc_jump_address_i = 32'h8000_0100;
        @(negedge clk);
        take_jump_i = 1'b0;
        vec++; if (if_busy_o !== 1'b1 || iport_stb_o !== 1'b1 || iport_addr_o !== 32'h8000_0008) begin errs++; $display("FAIL jmp_discard: got busy=%b stb=%b addr=%h required 1 1 80000008", if_busy_o, iport_stb_o, iport_addr_o); end
        bus_resp(32'hDEAD_BEEF, 1'b0);
        vec++; if (iport_cyc_o !== 1'b0 || id_pc_o !== 32'h8000_0004 || id_instruction_o !== 32'hA000_0004) begin errs++; $display("FAIL jmp_drop: got cyc=%b id=%h/%h required 0 80000004/a0000004", iport_cyc_o, id_pc_o, id_instruction_o); end
        wait_stb();
        vec++; if (iport_addr_o !== 32'h8000_0100) begin errs++; $display("FAIL jmp_target: got %h required 80000100", iport_addr_o); end
        bus_resp(32'hB000_0100, 1'b0);
        vec++; if (id_pc_o !== 32'h8000_0100 || id_instruction_o !== 32'hB000_0100) begin errs++; $display("FAIL jmp_id: got %h/%h required 80000100/b0000100", id_pc_o, id_instruction_o); end
    endtask

    task automatic test_err();
        take_branch_i = 1'b1; pc_branch_address_i = 32'h8000_0010;
        @(negedge clk);
        take_branch_i = 1'b0;
        wait_stb();
        vec++; if (iport_addr_o !== 32'h8000_0010) begin errs++; $display("FAIL err_addr: got %h required 80000010", iport_addr_o); end
        bus_resp(32'h1234_5678, 1'b1);
        vec++; if (id_instruction_o !== NOP || id_inst_access_fault_o !== 1'b1 || id_pc_o !== 32'h8000_0010) begin errs++; $display("FAIL err_id: got %h fault=%b pc=%h required 00000013 1 80000010", id_instruction_o, id_inst_access_fault_o, id_pc_o); end
        wait_stb();
        vec++; if (iport_addr_o !== 32'h8000_0014) begin errs++; $display("FAIL err_next: got %h required 80000014", iport_addr_o); end
        bus_resp(32'hC000_0014, 1'b0);
        vec++; if (id_inst_access_fault_o !== 1'b0 || id_instruction_o !== 32'hC000_0014) begin errs++; $display("FAIL err_clear: got fault=%b inst=%h required 0 c0000014", id_inst_access_fault_o, id_instruction_o); end
    endtask

    task automatic test_misaligned();
        take_branch_i = 1'b1; pc_branch_address_i = 32'h8000_0202;
        @(negedge clk);
        take_branch_i = 1'b0;
        vec++; if (iport_cyc_o !== 1'b0) begin errs++; $display("FAIL mis_cyc0: got %b required 0", iport_cyc_o); end
        @(negedge clk);
        vec++; if (iport_cyc_o !== 1'b0) begin errs++; $display("FAIL mis_cyc1: got %b required 0", iport_cyc_o); end
        vec++; if (id_pc_o !== 32'h8000_0202 || id_instruction_o !== NOP || id_inst_addr_misaligned_o !== 1'b1 || id_inst_access_fault_o !== 1'b0) begin errs++; $display("FAIL mis_id: got %h/%h mis=%b fault=%b required 80000202/00000013 1 0", id_pc_o, id_instruction_o, id_inst_addr_misaligned_o, id_inst_access_fault_o); end
    endtask

    task automatic test_stall();
        take_jump_i = 1'b1; pc_jump_address_i = 32'h8000_0300;
        @(negedge clk);
        take_jump_i = 1'b0;
        wait_stb();
        vec++; if (iport_addr_o !== 32'h8000_0300) begin errs++; $display("FAIL stall_addr: got %h required 80000300", iport_addr_o); end
        if_stall_i = 1'b1;
        bus_resp(32'h5500_0300, 1'b0);
        vec++; if (iport_cyc_o !== 1'b0 || if_busy_o !== 1'b0) begin errs++; $display("FAIL stall_hold: got cyc=%b busy=%b required 0 0", iport_cyc_o, if_busy_o); end
        for (int i = 0; i < 3; i++) begin
            vec++; if (id_pc_o !== 32'h8000_0202 || id_instruction_o !== NOP || id_inst_addr_misaligned_o !== 1'b1) begin errs++; $display("FAIL stall_frozen%0d: got %h/%h mis=%b required 80000202/00000013 1", i, id_pc_o, id_instruction_o, id_inst_addr_misaligned_o); end
            if (i < 2) @(negedge clk);
        end
        if_stall_i = 1'b0;
        @(negedge clk);
        vec++; if (id_pc_o !== 32'h8000_0300 || id_instruction_o !== 32'h5500_0300 || id_inst_addr_misaligned_o !== 1'b0) begin errs++; $display("FAIL stall_release: got %h/%h mis=%b required 80000300/55000300 0", id_pc_o, id_instruction_o, id_inst_addr_misaligned_o); end
        wait_stb();
        vec++; if (iport_addr_o !== 32'h8000_0304) begin errs++; $display("FAIL stall_next: got %h required 80000304", iport_addr_o); end
        bus_resp(32'h5500_0304, 1'b0);
        vec++; if (id_pc_o !== 32'h8000_0304 || id_instruction_o !== 32'h5500_0304) begin errs++; $display("FAIL stall_after: got %h/%h required 80000304/55000304", id_pc_o, id_instruction_o); end
    endtask

    task automatic test_flush_trap();
        if_flush_i = 1'b1; if_stall_i = 1'b1;
        @(negedge clk);
        if_flush_i = 1'b0;
        vec++; if (id_pc_o !== 32'h8000_0308 || id_instruction_o !== NOP || id_inst_addr_misaligned_o !== 1'b0 || id_inst_access_fault_o !== 1'b0) begin errs++; $display("FAIL flush_id: got %h/%h mis=%b fault=%b required 80000308/00000013 0 0", id_pc_o, id_instruction_o, id_inst_addr_misaligned_o, id_inst_access_fault_o); end
        vec++; if (iport_stb_o !== 1'b1) begin errs++; $display("FAIL flush_fsm: got stb=%b required 1", iport_stb_o); end
        trap_valid_i = 1'b1; trap_pc_i = 32'h8000_0400;
        take_jump_i = 1'b1; pc_jump_address_i = 32'h8000_0500;
        @(negedge clk);
        trap_valid_i = 1'b0; take_jump_i = 1'b0;
        vec++; if (if_busy_o !== 1'b1 || iport_addr_o !== 32'h8000_0308) begin errs++; $display("FAIL trap_discard: got busy=%b addr=%h required 1 80000308", if_busy_o, iport_addr_o); end
        bus_resp(32'hBAAD_F00D, 1'b0);
        vec++; if (id_instruction_o !== NOP) begin errs++; $display("FAIL trap_drop: got %h required 00000013", id_instruction_o); end
        if_stall_i = 1'b0;
        wait_stb();
        vec++; if (iport_addr_o !== 32'h8000_0400) begin errs++; $display("FAIL trap_target: got %h required 80000400", iport_addr_o); end
        bus_resp(32'h7700_0400, 1'b0);
        vec++; if (id_pc_o !== 32'h8000_0400 || id_instruction_o !== 32'h7700_0400) begin errs++; $display("FAIL trap_id: got %h/%h required 80000400/77000400", id_pc_o, id_instruction_o); end
    endtask

    task automatic test_wrap();
        take_jump_i = 1'b1; pc_jump_address_i = 32'hFFFF_FFFC;
        @(negedge clk);
        take_jump_i = 1'b0;
        wait_stb();
        vec++; if (iport_addr_o !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_addr: got %h required fffffffc", iport_addr_o); end
        bus_resp(32'h9900_0000, 1'b0);
        wait_stb();
        vec++; if (iport_addr_o !== 32'h0) begin errs++; $display("FAIL wrap_next: got %h required 00000000", iport_addr_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec++; if (iport_cyc_o !== 1'b0 || iport_stb_o !== 1'b0 || if_busy_o !== 1'b0) begin errs++; $display("FAIL rstmid_drop: got cyc=%b stb=%b busy=%b required 0 0 0", iport_cyc_o, iport_stb_o, if_busy_o); end
        iport_ack_i = 1'b1; iport_dat_i = 32'hBADB_AD00;
        @(negedge clk);
        iport_ack_i = 1'b0; iport_dat_i = 32'h0;
        rst = 1'b0;
        vec++; if (id_pc_o !== 32'h0 || id_instruction_o !== NOP) begin errs++; $display("FAIL rstmid_id: got %h/%h required 00000000/00000013", id_pc_o, id_instruction_o); end
        wait_stb();
        vec++; if (iport_addr_o !== 32'h8000_0000) begin errs++; $display("FAIL rstmid_restart: got %h required 80000000", iport_addr_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_discard();
        test_err();
        test_misaligned();
        test_stall();
        test_flush_trap();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
